fw_ctrl: RTL

- Farm-way side traffic-light controller. It is the responder to the highway controller's invk_fw request.
- Sits idle at RED until invoked. It then runs an all-red clearance, a farm-way GREEN and a YELLOW, and hands right-of-way back with a one-cycle invk_hw pulse.
- Has its own dwell timer, so it needs no external timeout inputs. Light encoding is shared with the highway side: RED=2'd0, GREEN=2'd1, YELLOW=2'd2.

---
 rtl/fw_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fw_ctrl.sv
// fw_ctrl: farm-way traffic-light controller.
// Waits at RED for invk_fw, then runs all-red CLEAR, GREEN and YELLOW, and
// returns right-of-way to the highway controller with a one-cycle invk_hw.
// Optional feature macro: FW_GAP_OUT_EN ends GREEN early after GAP_CYCLES
// consecutive car-free cycles, once the minimum green (SHORT_CYCLES) is met.
//
// Handshake: invk_fw is a one-cycle request, accepted only when the FSM is
// IDLE; invk_hw is a one-cycle grant-back. Neither side waits on the other,
// so an invk_fw that arrives outside IDLE is dropped and sets the sticky
// proto_err flag.
module fw_ctrl #(
    parameter int SHORT_CYCLES = 4,
    parameter int LONG_CYCLES  = 16,
    parameter int GAP_CYCLES   = 3,
    parameter int TMR_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       invk_fw,
    input  logic       car_on_fw,
    output logic [1:0] light_fw,
    output logic       invk_hw,
    output logic       proto_err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        GREEN  = 2'd2,
        YELLOW = 2'd3
    } state_t;

    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_GREEN  = 2'd1;
    localparam logic [1:0] LIGHT_YELLOW = 2'd2;

    localparam logic [TMR_W-1:0] SHORT_LAST = TMR_W'(SHORT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LONG_LAST  = TMR_W'(LONG_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] timer;
    logic [1:0]       light_next;
    logic             gap_out;

    assign dbg_state = state;

`ifdef FW_GAP_OUT_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [GAP_W-1:0] gap_cnt;

    // Gap exit needs the gap still open this cycle and minimum green served.
    assign gap_out = !car_on_fw && (gap_cnt == GAP_LAST) && (timer >= SHORT_LAST);

    // Consecutive car-free cycle counter, saturating, cleared on GREEN entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state != GREEN) begin
            gap_cnt <= '0;
        end else if (car_on_fw) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end
`else
    // Without gap-out the sensor has no effect; it is only referenced here.
    assign gap_out = 1'b0 & car_on_fw;
`endif

    // Next-state and lamp decode of the next state.
    always_comb begin
        state_next = state;
        light_next = LIGHT_RED;
        case (state)
            IDLE:    if (invk_fw) state_next = CLEAR;
            CLEAR:   if (timer == SHORT_LAST) state_next = GREEN;
            GREEN:   if ((timer == LONG_LAST) || gap_out) state_next = YELLOW;
            YELLOW:  if (timer == SHORT_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        case (state_next)
            GREEN:   light_next = LIGHT_GREEN;
            YELLOW:  light_next = LIGHT_YELLOW;
            default: light_next = LIGHT_RED;
        endcase
    end

    // State register and dwell timer (restarts at 0 on every state entry).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == IDLE) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    // Registered outputs: lamp, hand-back pulse and sticky protocol error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            light_fw  <= LIGHT_RED;
            invk_hw   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            light_fw  <= light_next;
            invk_hw   <= (state == YELLOW) && (state_next == IDLE);
            proto_err <= proto_err | (invk_fw && (state != IDLE));
        end
    end

endmodule
